// File: rtl/multi_lane_pipe_if.sv
// -----------------------------------------------------------------------------
// multi_lane_pipe_if
// Groups the upstream word handshake, the per-word control fields and the
// downstream result handshake of multi_lane_pipe into one bundle.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid && ready are both high. The producer keeps data and controls
// stable while valid is high and ready is low.
//
// Signals:
//   i_in        [WIDTH]  data word                         (to pipe)
//   i_in_valid           i_in is valid this cycle          (to pipe)
//   o_in_ready           pipe accepts i_in this cycle      (from pipe)
//   i_mode      [2]      00 PASS, 01 ADD, 10 ROT, 11 PASS  (to pipe)
//   i_combine            0 select lane, 1 XOR all lanes    (to pipe)
//   i_lane_sel  [6]      lane index                        (to pipe)
//   o_out       [WIDTH]  result word                       (from pipe)
//   o_out_valid          o_out is valid                    (from pipe)
//   i_out_ready          downstream accepts o_out          (to pipe)
//   o_out_count [CNT_W]  saturating delivered-word count   (from pipe)
//   o_sel_err            sticky out-of-range lane_sel flag (from pipe)
//
// Modports: master = traffic source/sink side, slave = the pipe itself.
// -----------------------------------------------------------------------------
interface multi_lane_pipe_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic [WIDTH-1:0] i_in;
   logic             i_in_valid;
   logic             o_in_ready;
   logic [1:0]       i_mode;
   logic             i_combine;
   logic [5:0]       i_lane_sel;
   logic [WIDTH-1:0] o_out;
   logic             o_out_valid;
   logic             i_out_ready;
   logic [CNT_W-1:0] o_out_count;
   logic             o_sel_err;

   modport master (
      output i_in, i_in_valid, i_mode, i_combine, i_lane_sel, i_out_ready,
      input  o_in_ready, o_out, o_out_valid, o_out_count, o_sel_err
   );

   modport slave (
      input  i_in, i_in_valid, i_mode, i_combine, i_lane_sel, i_out_ready,
      output o_in_ready, o_out, o_out_valid, o_out_count, o_sel_err
   );
endinterface

// File: rtl/multi_lane_pipe.sv
// -----------------------------------------------------------------------------
// multi_lane_pipe
// Broadcasts each accepted word to CHANNEL lanes. Every lane is a chain of
// DEPTH+1 registers (stage 0 .. stage DEPTH); each hop stage s -> s+1 applies
// the word's operation (PASS, ADD lane+1, ROT left by 1), so stage DEPTH holds
// the result of DEPTH operations. An output register then picks one lane or the
// XOR of all lanes. Latency from accepting edge to o_out_valid is DEPTH+1.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (clears valids, data, out, count, err)
//   bus  multi_lane_pipe_if.slave (word in, controls, result out, status)
//
// Optional feature macro: MULTI_LANE_PIPE_STALL_EN
//   defined   : backpressure; stall = o_out_valid && !i_out_ready freezes the
//               whole pipe and output, o_in_ready = !stall, count on handshake.
//   undefined : o_in_ready = 1, i_out_ready ignored, count on every out_valid.
// -----------------------------------------------------------------------------
module multi_lane_pipe #(
   parameter int WIDTH   = 32,
   parameter int CHANNEL = 20,
   parameter int DEPTH   = 12,
   parameter int CNT_W   = 16
) (
   input logic                clk,
   input logic                rst,
   multi_lane_pipe_if.slave   bus
);

   localparam logic [1:0] MODE_ADD = 2'b01;
   localparam logic [1:0] MODE_ROT = 2'b10;

   // Per-stage control, shared by all lanes since every lane carries the same word.
   logic [DEPTH:0]   r_vld;
   logic [1:0]       r_mode [DEPTH+1];
   logic             r_comb [DEPTH+1];
   logic [5:0]       r_sel  [DEPTH+1];

   logic [WIDTH-1:0] r_out;
   logic             r_out_valid;
   logic [CNT_W-1:0] r_count;
   logic             r_sel_err;

   logic             w_stall;
   logic             w_deliver;
   logic             w_accept;
   logic [WIDTH-1:0] w_last [CHANNEL];
   logic [WIDTH-1:0] w_xor;
   logic [WIDTH-1:0] w_pick;
   logic             w_sel_bad;

`ifdef MULTI_LANE_PIPE_STALL_EN
   assign w_stall   = r_out_valid && !bus.i_out_ready;
   assign w_deliver = r_out_valid && bus.i_out_ready;
`else
   logic w_unused_out_ready;
   assign w_unused_out_ready = bus.i_out_ready;
   assign w_stall   = 1'b0;
   assign w_deliver = r_out_valid;
`endif

   assign bus.o_in_ready = !w_stall;
   assign w_accept       = bus.i_in_valid && !w_stall;

   function automatic logic [WIDTH-1:0] f_op(input logic [WIDTH-1:0] x,
                                             input logic [1:0]       m,
                                             input logic [WIDTH-1:0] inc);
      case (m)
         MODE_ADD: f_op = x + inc;
         MODE_ROT: f_op = {x[WIDTH-2:0], x[WIDTH-1]};
         default:  f_op = x;
      endcase
   endfunction

   // Control pipeline: stage 0 always samples the inputs; only r_vld decides
   // whether a stage carries a real word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         for (int s = 0; s <= DEPTH; s++) begin
            r_mode[s] <= '0;
            r_comb[s] <= 1'b0;
            r_sel[s]  <= '0;
         end
      end else if (!w_stall) begin
         r_vld     <= {r_vld[DEPTH-1:0], w_accept};
         r_mode[0] <= bus.i_mode;
         r_comb[0] <= bus.i_combine;
         r_sel[0]  <= bus.i_lane_sel;
         for (int s = 0; s < DEPTH; s++) begin
            r_mode[s+1] <= r_mode[s];
            r_comb[s+1] <= r_comb[s];
            r_sel[s+1]  <= r_sel[s];
         end
      end
   end

   // Lane datapaths; each lane owns its data chain.
   for (genvar c = 0; c < CHANNEL; c++) begin : g_lane
      localparam logic [WIDTH-1:0] INC = WIDTH'(c + 1);
      logic [WIDTH-1:0] r_data [DEPTH+1];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 0; s <= DEPTH; s++) r_data[s] <= '0;
         end else if (!w_stall) begin
            r_data[0] <= bus.i_in;
            for (int s = 0; s < DEPTH; s++)
               r_data[s+1] <= f_op(r_data[s], r_mode[s], INC);
         end
      end

      assign w_last[c] = r_data[DEPTH];
   end

   // Lane selection / reduction from the last stage.
   always_comb begin
      w_xor  = '0;
      w_pick = '0;
      for (int c = 0; c < CHANNEL; c++) begin
         w_xor = w_xor ^ w_last[c];
         if (r_sel[DEPTH] == 6'(c)) w_pick = w_last[c];
      end
      w_sel_bad = ({1'b0, r_sel[DEPTH]} >= 7'(CHANNEL));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_count     <= '0;
         r_sel_err   <= 1'b0;
      end else begin
         if (!w_stall) begin
            r_out_valid <= r_vld[DEPTH];
            if (r_vld[DEPTH]) begin
               // An out-of-range lane yields 0 (w_pick stays at its default).
               r_out <= r_comb[DEPTH] ? w_xor : w_pick;
               if (!r_comb[DEPTH] && w_sel_bad) r_sel_err <= 1'b1;
            end
         end
         if (w_deliver && (r_count != '1)) r_count <= r_count + 1'b1;
      end
   end

   assign bus.o_out       = r_out;
   assign bus.o_out_valid = r_out_valid;
   assign bus.o_out_count = r_count;
   assign bus.o_sel_err   = r_sel_err;

endmodule

// File: doc/multi_lane_pipe.md
Name: multi_lane_pipe

Overview:
- Parametrised multi-channel datapath for the random-design regression suite; successor to the fixed WIDTH/CHANNEL top-level designs.
- Broadcasts each input word to CHANNEL parallel lanes. Each lane is a DEPTH-stage pipeline with a per-word selectable operation.
- Outputs either one selected lane or the XOR reduction of all lanes, with valid tracking, a word counter and error flagging.

Parameters:
- WIDTH, 32, data width in bits (≥2)
- CHANNEL, 20, number of parallel lanes (1..64)
- DEPTH, 12, pipeline stages per lane (≥1)
- CNT_W, 16, width of the output word counter

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous and active-high
- in  input  WIDTH  data word
- in_valid  input  1  in is valid this cycle
- in_ready  output  1  block accepts in this cycle
- mode  input  2  operation, sampled with the word: 00 PASS, 01 ADD, 10 ROT, 11 treated as PASS
- combine  input  1  sampled with the word: 0 = select lane, 1 = XOR-reduce all lanes
- lane_sel  input  6  lane index, sampled with the word
- out  output  WIDTH  result word
- out_valid  output  1  out is valid
- out_ready  input  1  downstream accepts out (honoured only with the optional feature)
- out_count  output  CNT_W  number of words delivered, saturating
- sel_err  output  1  sticky flag: a word arrived with lane_sel ≥ CHANNEL

Behaviour:
- Reset: all stage valids = 0, out = 0, out_valid = 0, out_count = 0, sel_err = 0. Stage data registers are also cleared to 0.
- Reset mid-operation discards every in-flight word; nothing in flight is delivered after reset deasserts.
- Accept: a word is accepted when in_valid && in_ready. Stage 0 of every lane captures in, mode, combine and lane_sel.
- Per-word control: mode, combine and lane_sel travel down the pipe with their word. Changing them mid-stream affects only newly accepted words.
- Stage operation, stage s → s+1 of lane c (c = 0..CHANNEL-1):
  - PASS: x unchanged.
  - ADD: x + (c+1), modulo 2^WIDTH.
  - ROT: x rotated left by 1.
- Net effect after DEPTH stages:
  - ADD gives in + DEPTH·(c+1) mod 2^WIDTH.
  - ROT gives rotl(in, DEPTH mod WIDTH).
- Output register, loaded when the last stage holds a valid word:
  - combine = 0: out = lane[lane_sel]. If lane_sel ≥ CHANNEL, out = 0 and sel_err is set; sel_err stays set until rst.
  - combine = 1: out = XOR of all CHANNEL lanes; lane_sel is ignored.
- Latency: exactly DEPTH+1 cycles from the accepting edge to out_valid = 1. Throughput is one word per cycle.
- out_valid follows the last stage valid. When no valid word arrives, out holds its last value.
- out_count increments by 1 on each cycle with out_valid && (out_ready, or always when the optional feature is absent). It saturates at 2^CNT_W−1 and does not wrap.
- Bubbles (in_valid = 0) propagate as invalid stages. Data registers in invalid stages may update, but the output register ignores them.

Optional Feature:
- Macro: MULTI_LANE_PIPE_STALL_EN.
- Defined:
  - Backpressure is enabled. stall = out_valid && !out_ready.
  - While stall is high, every stage, the output register and the valids hold their values.
  - in_ready = !stall, and no word is lost or duplicated.
  - out_count increments only on out_valid && out_ready.
- Undefined:
  - in_ready is tied to 1 and out_ready is ignored.
  - The pipe never stalls, and out_count increments on every out_valid.

Test Plan (WIDTH=32, CHANNEL=20, DEPTH=12):
- After rst, one word in=0xABCDEFAB, mode=PASS, combine=0, lane_sel=3 → out=0xABCDEFAB with out_valid high exactly 13 cycles after acceptance; out_count=1.
- Burst of in=0x12345678, mode=ADD, combine=0, lane_sel=0 then lane_sel=19 on consecutive cycles → out=0x12345684, then 0x12345768 on consecutive cycles.
- in=0x80000001, mode=ROT, lane_sel=5 → out=0x00001800. Then mode=PASS with combine=1, in=0xAAAAAAAA → out=0 (even lane count).
- Word with lane_sel=25 → out=0 and sel_err=1. sel_err stays 1 through later valid words and clears only on rst.
- Eight back-to-back words, rst pulsed for 1 cycle at cycle 5 → no out_valid for any pre-reset word, out_count=0. A new word after reset arrives 13 cycles later.
- With MULTI_LANE_PIPE_STALL_EN: continuous stream of 30 words, out_ready low for 4 cycles mid-stream → in_ready low during the stall. All 30 words are delivered in order with no duplicates, and out_count=30.
